// File: rtl/home_inventory_pkg.sv
// Shared definitions for the home-inventory sample framer: channel count,
// index/data/timestamp widths and the framer FSM encoding.
package home_inventory_pkg;

    localparam int NCH    = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 32;
    localparam int TS_W   = 32;

    localparam logic [NCH-1:0] MASK_FULL = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/home_inventory_ts_counter.sv
// Prescaled free-running timestamp; skips zero on wrap so that 0 only ever
// means "fresh out of reset".
module home_inventory_ts_counter
    import home_inventory_pkg::*;
#(
    parameter int TS_DIV = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [TS_W-1:0] ts_ctr
);

    localparam logic [15:0] PRE_LAST = 16'(TS_DIV - 1);

    logic [15:0]     pre_q, pre_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            tick;

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? 16'd0 : pre_q + 16'd1;
        ts_d  = ts_q;
        if (tick) begin
            ts_d = (ts_q == '1) ? TS_W'(1) : ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ts_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ts_q  <= ts_d;
        end
    end

    assign ts_ctr = ts_q;

endmodule

// File: rtl/home_inventory_sample_framer.sv
// Gathers one conversion per channel into a timestamped frame, presents it
// for one cycle, and counts frames lost to duplicates, timeout or disable.
module home_inventory_sample_framer
    import home_inventory_pkg::*;
#(
    parameter int TS_DIV      = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              sample_valid,
    output logic [TS_W-1:0]   ts_now,
    output logic [DATA_W-1:0] sample_ch0,
    output logic [DATA_W-1:0] sample_ch1,
    output logic [DATA_W-1:0] sample_ch2,
    output logic [DATA_W-1:0] sample_ch3,
    output logic [DATA_W-1:0] sample_ch4,
    output logic [DATA_W-1:0] sample_ch5,
    output logic [DATA_W-1:0] sample_ch6,
    output logic [DATA_W-1:0] sample_ch7,
    output logic [15:0]       drop_count,
    input  logic              drop_clr
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t                       state_q, state_d;
    logic [NCH-1:0]               mask_q, mask_d;
    logic [NCH-1:0][DATA_W-1:0]   staging_q, staging_d;
    logic [NCH-1:0][DATA_W-1:0]   samples_q, samples_d;
    logic [TS_W-1:0]              ts_stage_q, ts_stage_d;
    logic [TS_W-1:0]              ts_now_q, ts_now_d;
    logic [15:0]                  tmo_q, tmo_d;
    logic [15:0]                  drop_count_q, drop_count_d;
    logic                         sample_valid_q, sample_valid_d;
    logic [TS_W-1:0]              ts_ctr;
    logic                         accept;
    logic                         drop;
    logic [NCH-1:0]               ch_bit;

    home_inventory_ts_counter #(
        .TS_DIV (TS_DIV)
    ) u_ts (
        .clk    (clk),
        .rst_n  (rst_n),
        .ts_ctr (ts_ctr)
    );

    assign in_ready = rst_n && enable && (state_q != ST_EMIT);
    assign accept   = in_valid && in_ready;
    assign ch_bit   = NCH'(1) << in_ch;

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        staging_d      = staging_q;
        samples_d      = samples_q;
        ts_stage_d     = ts_stage_q;
        ts_now_d       = ts_now_q;
        tmo_d          = tmo_q;
        sample_valid_d = 1'b0;
        drop           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    staging_d[in_ch] = in_data;
                    mask_d           = ch_bit;
                    ts_stage_d       = ts_ctr;
                    tmo_d            = '0;
                    state_d          = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!enable) begin
                    drop    = 1'b1;
                    mask_d  = '0;
                    state_d = ST_IDLE;
                end else if (accept && ((mask_q & ch_bit) != '0)) begin
                    // A duplicate supersedes any same-cycle timeout: one drop, new frame.
                    drop             = 1'b1;
                    staging_d[in_ch] = in_data;
                    mask_d           = ch_bit;
                    ts_stage_d       = ts_ctr;
                    tmo_d            = '0;
                end else begin
                    if (accept) begin
                        staging_d[in_ch] = in_data;
                        mask_d           = mask_q | ch_bit;
                    end
                    if (mask_d == MASK_FULL) begin
                        state_d        = ST_EMIT;
                        sample_valid_d = 1'b1;
                        samples_d      = staging_d;
                        ts_now_d       = ts_stage_q;
                    end else if (tmo_q == TMO_LAST) begin
                        drop    = 1'b1;
                        mask_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            ST_EMIT: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        drop_count_d = drop_count_q;
        if (drop_clr) begin
            drop_count_d = '0;
        end else if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mask_q         <= '0;
            staging_q      <= '0;
            samples_q      <= '0;
            ts_stage_q     <= '0;
            ts_now_q       <= '0;
            tmo_q          <= '0;
            drop_count_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            staging_q      <= staging_d;
            samples_q      <= samples_d;
            ts_stage_q     <= ts_stage_d;
            ts_now_q       <= ts_now_d;
            tmo_q          <= tmo_d;
            drop_count_q   <= drop_count_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign ts_now       = ts_now_q;
    assign drop_count   = drop_count_q;
    assign sample_ch0   = samples_q[0];
    assign sample_ch1   = samples_q[1];
    assign sample_ch2   = samples_q[2];
    assign sample_ch3   = samples_q[3];
    assign sample_ch4   = samples_q[4];
    assign sample_ch5   = samples_q[5];
    assign sample_ch6   = samples_q[6];
    assign sample_ch7   = samples_q[7];

endmodule
